// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field layout, int32 limits,
// rounding-mode codes, the ftoi operand classes and float field helpers.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    localparam int RND_RNE = 0;
    localparam int RND_RTZ = 1;

    // Biased-exponent thresholds for the ftoi datapath.
    localparam logic [EXP_W-1:0] EXP_RSH_MIN = 8'd126;  // 0.5 <= |x|
    localparam logic [EXP_W-1:0] EXP_LSH_MIN = 8'd150;  // mantissa already integral
    localparam logic [EXP_W-1:0] EXP_OVF_MIN = 8'd158;  // |x| >= 2^31
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;   // inf / NaN

    // -2^31 is the single finite value with e == 158 that still fits in int32.
    localparam logic [31:0] F_INT_MIN = 32'hCF00_0000;

    typedef enum logic [2:0] {
        CLS_ZERO    = 3'd0,
        CLS_RSHIFT  = 3'd1,
        CLS_LSHIFT  = 3'd2,
        CLS_INT_MIN = 3'd3,
        CLS_OVF     = 3'd4,
        CLS_NAN     = 3'd5
    } ftoi_cls_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float_t;

    // Decoded operand held in the first pipeline stage.
    typedef struct packed {
        logic          sign;
        ftoi_cls_e     cls;
        logic [4:0]    shamt;
        logic [FRAC_W:0] man;
    } ftoi_s1_t;

    function automatic float_t f_unpack(input logic [31:0] f);
        return float_t'(f);
    endfunction

    // Mantissa with the hidden bit restored (zero for denormals / zero).
    function automatic logic [FRAC_W:0] f_man(input logic [EXP_W-1:0] e,
                                              input logic [FRAC_W-1:0] frac);
        return {(e != 8'd0), frac};
    endfunction

endpackage

// File: rtl/rshift_sticky.sv
// 24-bit mantissa right shifter returning the kept integer bits, the guard
// bit (first dropped bit) and the sticky OR of every bit below the guard.
// Purely combinational; shift amounts 1..24 are expected.
module rshift_sticky
    import fpu_pkg::*;
(
    input  logic [FRAC_W:0] man_i,
    input  logic [4:0]      shamt_i,
    output logic [FRAC_W:0] shifted_o,
    output logic            guard_o,
    output logic            sticky_o
);

    logic [48:0] wide_s;

    // Shift the mantissa into a 49-bit window so every dropped bit is kept below it.
    always_comb begin
        wide_s    = {man_i, 25'd0} >> shamt_i;
        shifted_o = wide_s[48:25];
        guard_o   = wide_s[24];
        sticky_o  = |wide_s[23:0];
    end

endmodule

// File: rtl/ftoi_pipe.sv
// Pipelined single-precision float to int32 converter.
// S1 register: unpack/classify; S2 logic: shift, round, negate into the
// output register. Two-cycle latency, 1 op/cycle, whole pipe stalls together.
// Build option: define FTOI_SAT_EN to saturate overflows (+ -> INT_MAX,
// - -> INT_MIN, NaN -> 0) instead of returning INT_MIN for every overflow.
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter int RND_MODE = 0
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf
);

    logic            advance_s;
    float_t          op_f_s;
    ftoi_s1_t        dec_s;

    ftoi_s1_t        s1_q, s1_d;
    logic            s1_valid_q, s1_valid_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     result_q, result_d;
    logic            ovf_q, ovf_d;

    logic [FRAC_W:0] shifted_s;
    logic            guard_s;
    logic            sticky_s;
    logic            round_inc_s;
    logic [31:0]     mag_s;
    logic [31:0]     signed_s;
    logic [31:0]     conv_res_s;
    logic            conv_ovf_s;

    // Global stall: everything moves only when the output slot can be freed.
    always_comb begin
        advance_s = ~out_valid_q | out_ready;
    end

    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

    // S1 decode: classify the operand and precompute the shift distance.
    // Shift amounts use modular arithmetic on the low exponent bits:
    // (150 - e) mod 32 == 22 - e[4:0], (e - 150) mod 8 == e[2:0] - 6.
    always_comb begin
        op_f_s      = f_unpack(op);
        dec_s.sign  = op_f_s.sign;
        dec_s.man   = f_man(op_f_s.exp, op_f_s.frac);
        dec_s.shamt = 5'd0;
        dec_s.cls   = CLS_ZERO;
        if (op_f_s.exp == EXP_SPECIAL) begin
            if (op_f_s.frac != 23'd0) begin
                dec_s.cls = CLS_NAN;
            end else begin
                dec_s.cls = CLS_OVF;
            end
        end else if (op == F_INT_MIN) begin
            dec_s.cls = CLS_INT_MIN;
        end else if (op_f_s.exp >= EXP_OVF_MIN) begin
            dec_s.cls = CLS_OVF;
        end else if (op_f_s.exp >= EXP_LSH_MIN) begin
            dec_s.cls   = CLS_LSHIFT;
            dec_s.shamt = {2'b00, op_f_s.exp[2:0] - 3'd6};
        end else if (op_f_s.exp >= EXP_RSH_MIN) begin
            dec_s.cls   = CLS_RSHIFT;
            dec_s.shamt = 5'd22 - op_f_s.exp[4:0];
        end else begin
            dec_s.cls = CLS_ZERO;
        end
    end

    // S1 next state: load a new op on advance, otherwise hold.
    always_comb begin
        s1_d       = s1_q;
        s1_valid_d = s1_valid_q;
        if (advance_s) begin
            s1_d       = dec_s;
            s1_valid_d = in_valid;
        end else begin
            s1_d       = s1_q;
            s1_valid_d = s1_valid_q;
        end
    end

    rshift_sticky u_rsh (
        .man_i     (s1_q.man),
        .shamt_i   (s1_q.shamt),
        .shifted_o (shifted_s),
        .guard_o   (guard_s),
        .sticky_o  (sticky_s)
    );

    // Rounding increment: nearest-even uses guard/sticky/lsb, truncation never rounds.
    always_comb begin
        round_inc_s = 1'b0;
        if (RND_MODE == RND_RNE) begin
            round_inc_s = guard_s & (sticky_s | shifted_s[0]);
        end else begin
            round_inc_s = 1'b0;
        end
    end

    // S2 magnitude and sign: |x| < 2^31 for all in-range classes, so a 32-bit
    // negate is exact and no rounding carry can reach bit 31.
    always_comb begin
        mag_s = 32'd0;
        case (s1_q.cls)
            CLS_RSHIFT: mag_s = {8'd0, shifted_s} + {31'd0, round_inc_s};
            CLS_LSHIFT: mag_s = {8'd0, s1_q.man} << s1_q.shamt[2:0];
            default:    mag_s = 32'd0;
        endcase
        if (s1_q.sign) begin
            signed_s = 32'd0 - mag_s;
        end else begin
            signed_s = mag_s;
        end
    end

    // S2 result select including overflow / special-value policy.
    always_comb begin
        conv_res_s = 32'd0;
        conv_ovf_s = 1'b0;
        case (s1_q.cls)
            CLS_ZERO: begin
                conv_res_s = 32'd0;
                conv_ovf_s = 1'b0;
            end
            CLS_RSHIFT, CLS_LSHIFT: begin
                conv_res_s = signed_s;
                conv_ovf_s = 1'b0;
            end
            CLS_INT_MIN: begin
                conv_res_s = INT_MIN;
                conv_ovf_s = 1'b0;
            end
            CLS_OVF: begin
                conv_ovf_s = 1'b1;
`ifdef FTOI_SAT_EN
                conv_res_s = s1_q.sign ? INT_MIN : INT_MAX;
`else
                conv_res_s = INT_MIN;
`endif
            end
            CLS_NAN: begin
                conv_ovf_s = 1'b1;
`ifdef FTOI_SAT_EN
                conv_res_s = 32'd0;
`else
                conv_res_s = INT_MIN;
`endif
            end
            default: begin
                conv_res_s = 32'd0;
                conv_ovf_s = 1'b0;
            end
        endcase
    end

    // Output register next state: capture S2 on advance, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        if (advance_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = conv_res_s;
                ovf_d    = conv_ovf_s;
            end else begin
                result_d = result_q;
                ovf_d    = ovf_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with synchronous reset discarding in-flight ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 32'd0;
            ovf_q       <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: one RNE and one RTZ instance driven in
// lockstep, checked against an arithmetic reference model via a scoreboard.
module tb_ftoi_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] op;
    logic        out_ready;

    logic        rne_in_ready, rne_out_valid, rne_ovf;
    logic [31:0] rne_result;
    logic        rtz_in_ready, rtz_out_valid, rtz_ovf;
    logic [31:0] rtz_result;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    bit          stall_prev = 1'b0;
    logic [31:0] held_res;
    logic        held_ovf;
    bit          send_done;

    always #5 clk = ~clk;

    ftoi_pipe #(.RND_MODE(0)) u_rne (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rne_in_ready),
        .op(op), .out_valid(rne_out_valid), .out_ready(out_ready),
        .result(rne_result), .ovf(rne_ovf)
    );

    ftoi_pipe #(.RND_MODE(1)) u_rtz (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rtz_in_ready),
        .op(op), .out_valid(rtz_out_valid), .out_ready(out_ready),
        .result(rtz_result), .ovf(rtz_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: value = m * 2^(e-150), rounded by integer division/remainder.
    function automatic logic [32:0] ref_conv(input logic [31:0] f, input bit rtz);
        int          e;
        longint      m, den, q, r, mag;
        logic [31:0] res;
        bit          ovf;
        e   = int'(f[30:23]);
        m   = longint'({1'b1, f[22:0]});
        ovf = (e == 255) || (e >= 158 && f != 32'hCF00_0000);
        mag = 0;
        if (ovf) begin
`ifdef FTOI_SAT_EN
            if (e == 255 && f[22:0] != 23'd0) res = 32'h0000_0000;
            else if (f[31])                   res = 32'h8000_0000;
            else                              res = 32'h7FFF_FFFF;
`else
            res = 32'h8000_0000;
`endif
        end else if (f == 32'hCF00_0000) begin
            res = 32'h8000_0000;
        end else begin
            if (e < 126) begin
                mag = 0;
            end else if (e >= 150) begin
                mag = m * (longint'(1) << (e - 150));
            end else begin
                den = longint'(1) << (150 - e);
                q   = m / den;
                r   = m % den;
                if (!rtz && ((2 * r > den) || (2 * r == den && (q % 2) == 1))) q = q + 1;
                mag = q;
            end
            if (f[31]) mag = -mag;
            res = 32'(mag);
        end
        return {ovf, res};
    endfunction

    // Scoreboard monitor sampling on the falling edge.
    initial begin
        logic [31:0] o;
        logic [32:0] er, ez;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("hold_res", rne_result, held_res);
                    chk("hold_ovf", {31'd0, rne_ovf}, {31'd0, held_ovf});
                end
                if (rne_out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 32'd1, 32'd0);
                    end else begin
                        o  = exp_q.pop_front();
                        er = ref_conv(o, 1'b0);
                        ez = ref_conv(o, 1'b1);
                        chk("rne_res", rne_result, er[31:0]);
                        chk("rne_ovf", {31'd0, rne_ovf}, {31'd0, er[32]});
                        chk("rtz_vld", {31'd0, rtz_out_valid}, 32'd1);
                        chk("rtz_res", rtz_result, ez[31:0]);
                        chk("rtz_ovf", {31'd0, rtz_ovf}, {31'd0, ez[32]});
                    end
                end
                stall_prev = rne_out_valid && !out_ready;
                held_res   = rne_result;
                held_ovf   = rne_ovf;
                if (in_valid && rne_in_ready) exp_q.push_back(op);
            end
        end
    end

    task automatic send_op(input logic [31:0] v);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        op       = v;
        while (!acc) begin
            @(negedge clk);
            acc = rne_in_ready;
            @(posedge clk);
            #1;
            n++;
            if (!acc && n >= 100) begin
                chk("send_timeout", {31'd0, acc}, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] f;
        logic [22:0] frac;
        int          k;
        frac = 23'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            k    = $urandom_range(0, 22);
            frac = frac & (23'h7F_FFFF << k);
        end
        if ($urandom_range(0, 7) == 0) begin
            f = $urandom;
        end else begin
            f = {1'($urandom), 8'($urandom_range(118, 162)), frac};
        end
        return f;
    endfunction

    logic [31:0] dir_ops [0:19] = '{
        32'h3FC0_0000, 32'h4020_0000, 32'hC060_0000, 32'h3F00_0000, 32'h3F00_0001,
        32'h0000_0001, 32'hCF00_0000, 32'h4F00_0000, 32'h7FC0_0000, 32'hFF80_0000,
        32'h7F80_0000, 32'h8000_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h3F7F_FFFF,
        32'h4B00_0001, 32'hCF00_0001, 32'h3EFF_FFFF, 32'h4B7F_FFFF, 32'hBFC0_0000
    };

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op        = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_vld",   {31'd0, rne_out_valid}, 32'd0);
        chk("rst_res",   rne_result, 32'd0);
        chk("rst_ovf",   {31'd0, rne_ovf}, 32'd0);
        chk("rst_rdy",   {31'd0, rne_in_ready}, 32'd1);
        chk("rst_rtz_v", {31'd0, rtz_out_valid}, 32'd0);

        // Latency: accepted op appears exactly two edges later.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_op(32'h3FC0_0000);
        @(negedge clk);
        chk("lat_s1", {31'd0, rne_out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_s2", {31'd0, rne_out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Directed values, back-to-back.
        foreach (dir_ops[i]) send_op(dir_ops[i]);
        drain();

        // Full pipe with consumer stalled for several cycles.
        out_ready = 1'b0;
        fork
            begin
                send_op(32'h4040_0000);
                send_op(32'hC0A0_0000);
                send_op(32'h40E0_0000);
            end
            begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("full_rdy", {31'd0, rne_in_ready}, 32'd0);
                    chk("full_vld", {31'd0, rne_out_valid}, 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight.
        send_op(32'h4110_0000);
        send_op(32'h4120_0000);
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("flush_vld", {31'd0, rne_out_valid}, 32'd0);
        chk("flush_res", rne_result, 32'd0);
        chk("flush_ovf", {31'd0, rne_ovf}, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stale_vld", {31'd0, rne_out_valid}, 32'd0);
        end

        // Random traffic with random consumer back-pressure.
        @(posedge clk);
        #1;
        send_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send_op(rand_op());
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                send_done = 1'b1;
            end
            begin
                while (!send_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
